// File: rtl/l2_bist_pkg.sv
// Shared types, pattern-mode encodings and expected-data generator for the L2 memory BIST.
package l2_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_WAIT,
    DONE
  } bist_state_e;

  localparam logic [1:0] MODE_FIXED = 2'b00;
  localparam logic [1:0] MODE_ADDR  = 2'b01;
  localparam logic [1:0] MODE_INV   = 2'b10;
  localparam logic [1:0] MODE_ALT   = 2'b11;

  // Widest data word supported; callers zero-extend inputs and truncate the result.
  localparam int MAX_DW = 512;

  function automatic logic [MAX_DW-1:0] exp_data(
    input logic [1:0]        mode,
    input logic [MAX_DW-1:0] pattern,
    input logic [MAX_DW-1:0] addr,
    input logic              idx_odd
  );
    logic [MAX_DW-1:0] d;
    case (mode)
      MODE_FIXED: d = pattern;
      MODE_ADDR:  d = addr;
      MODE_INV:   d = ~pattern;
      default:    d = idx_odd ? ~pattern : pattern;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/l2_mem_if.sv
// L2 request/grant/rvalid memory port shared by the BIST master and the memory side.
interface l2_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic                    gnt;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/l2_bist_checker.sv
// Read-back comparator: saturating mismatch counter plus capture of the first failing word.
module l2_bist_checker #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  check_en,
  input  logic [DATA_WIDTH-1:0] expected,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data
);

  logic mismatch;

  assign mismatch = check_en && (rdata != expected);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (clear) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (mismatch) begin
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + CNT_WIDTH'(1);
      end
      // A zero count means this is the first mismatch of the run.
      if (err_cnt == '0) begin
        first_err_addr <= addr;
        first_err_data <= rdata;
      end
    end
  end

endmodule

// File: rtl/l2_mem_bist.sv
// L2 memory BIST engine: writes a generated pattern over an address range,
// then reads it back one word at a time and reports mismatches.
module l2_mem_bist
  import l2_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  num_words_i,
  input  logic [DATA_WIDTH-1:0] pattern_i,
  input  logic [1:0]            mode_i,
  l2_mem_if.master              mem,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  aborted_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic [DATA_WIDTH-1:0] first_err_data_o
);

  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

  bist_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, addr_q;
  logic [CNT_WIDTH-1:0]  num_q, idx_q;
  logic [DATA_WIDTH-1:0] pattern_q, exp_word;
  logic [1:0]            mode_q;
  logic                  drain_q, done_q, pass_q, aborted_q;
  logic                  start_acc, last_word, pass_now;
  logic                  advance, rd_restart, abort_end, check_en;

  assign start_acc = (state_q == IDLE) && start_i;
  assign last_word = (idx_q == num_q - CNT_WIDTH'(1));
  assign exp_word  = DATA_WIDTH'(exp_data(mode_q, MAX_DW'(pattern_q), MAX_DW'(addr_q), idx_q[0]));
  assign pass_now  = (err_cnt_o == '0) && !aborted_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the per-cycle datapath strobes; an abort drops an ungranted
  // request at once but a granted read still owes its rvalid, tracked by drain_q.
  always_comb begin
    state_d    = state_q;
    advance    = 1'b0;
    rd_restart = 1'b0;
    abort_end  = 1'b0;
    check_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (num_words_i == '0) ? DONE : WR;
        end
      end
      WR: begin
        if (mem.gnt && !abort_i) begin
          if (last_word) begin
            state_d    = RD_REQ;
            rd_restart = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end else if (abort_i) begin
          state_d   = DONE;
          abort_end = 1'b1;
        end
      end
      RD_REQ: begin
        if (mem.gnt) begin
          state_d = RD_WAIT;
        end else if (abort_i) begin
          state_d   = DONE;
          abort_end = 1'b1;
        end
      end
      RD_WAIT: begin
        if (mem.rvalid) begin
          if (abort_i || drain_q) begin
            state_d   = DONE;
            abort_end = 1'b1;
          end else begin
            check_en = 1'b1;
            if (last_word) begin
              state_d = DONE;
            end else begin
              state_d = RD_REQ;
              advance = 1'b1;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      addr_q    <= '0;
      num_q     <= '0;
      idx_q     <= '0;
      pattern_q <= '0;
      mode_q    <= MODE_FIXED;
      drain_q   <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (start_acc) begin
        base_q    <= base_addr_i;
        addr_q    <= base_addr_i;
        num_q     <= num_words_i;
        idx_q     <= '0;
        pattern_q <= pattern_i;
        mode_q    <= mode_i;
        done_q    <= 1'b0;
        pass_q    <= 1'b0;
        aborted_q <= 1'b0;
      end else if (advance) begin
        addr_q <= addr_q + WORD_BYTES;
        idx_q  <= idx_q + CNT_WIDTH'(1);
      end else if (rd_restart) begin
        addr_q <= base_q;
        idx_q  <= '0;
      end
      drain_q <= (state_d == RD_WAIT) && (drain_q || abort_i);
      if (abort_end) begin
        aborted_q <= 1'b1;
      end
      if (state_q == DONE) begin
        done_q <= 1'b1;
        pass_q <= pass_now;
      end
    end
  end

  l2_bist_checker #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_checker (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .clear         (start_acc),
    .check_en      (check_en),
    .expected      (exp_word),
    .rdata         (mem.rdata),
    .addr          (addr_q),
    .err_cnt       (err_cnt_o),
    .first_err_addr(first_err_addr_o),
    .first_err_data(first_err_data_o)
  );

  assign mem.req   = (state_q == WR) || (state_q == RD_REQ);
  assign mem.we    = (state_q == WR);
  assign mem.addr  = addr_q;
  assign mem.wdata = exp_word;
  assign mem.be    = {(DATA_WIDTH/8){1'b1}};

  assign busy_o    = (state_q == WR) || (state_q == RD_REQ) || (state_q == RD_WAIT);
  assign done_o    = done_q || (state_q == DONE);
  assign pass_o    = (state_q == DONE) ? pass_now : pass_q;
  assign aborted_o = aborted_q;

endmodule
